// File: rtl/axi4_lite_slave_arb.sv
// axi4_lite_slave_arb: AXI4-Lite slave funnelling reads and writes onto one round-robin arbitrated register port
module axi4_lite_slave_arb #(
  parameter int addr_width     = 7,
  parameter int data_width     = 32,
  parameter int timeout_cycles = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  output logic                      reg_req_o,
  output logic                      reg_we_o,
  output logic [addr_width-1:0]     reg_addr_o,
  output logic [data_width-1:0]     reg_wdata_o,
  output logic [data_width/8-1:0]   reg_wmask_o,
  input  logic                      reg_ack_i,
  input  logic                      reg_err_i,
  input  logic [data_width-1:0]     reg_rdata_i,
  input  logic [addr_width-1:0]     s_axi_awaddr_i,
  input  logic [2:0]                s_axi_awprot_i,
  input  logic                      s_axi_awvalid_i,
  output logic                      s_axi_awready_o,
  input  logic [data_width-1:0]     s_axi_wdata_i,
  input  logic [data_width/8-1:0]   s_axi_wstrb_i,
  input  logic                      s_axi_wvalid_i,
  output logic                      s_axi_wready_o,
  output logic [1:0]                s_axi_bresp_o,
  output logic                      s_axi_bvalid_o,
  input  logic                      s_axi_bready_i,
  input  logic [addr_width-1:0]     s_axi_araddr_i,
  input  logic [2:0]                s_axi_arprot_i,
  input  logic                      s_axi_arvalid_i,
  output logic                      s_axi_arready_o,
  output logic [data_width-1:0]     s_axi_rdata_o,
  output logic [1:0]                s_axi_rresp_o,
  output logic                      s_axi_rvalid_o,
  input  logic                      s_axi_rready_i
);
  localparam int lsb = $clog2(data_width / 8);
  localparam int cw = timeout_cycles > 0 ? $clog2(timeout_cycles + 1) : 1;
  localparam logic [addr_width-1:0] amask = {addr_width{1'b1}} << lsb;
  typedef enum logic {IDLE, ACCESS} state_e;
  state_e                    state_q;
  logic                      aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
  logic [addr_width-1:0]     aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
  logic [data_width-1:0]     w_data_q, w_data_d;
  logic [data_width/8-1:0]   w_strb_q, w_strb_d;
  logic                      aw_rdy_q, w_rdy_q, ar_rdy_q;
  logic                      wr_iss_q, wr_iss_d, rd_iss_q, rd_iss_d, last_wr_q;
  logic                      req_q, we_q;
  logic [addr_width-1:0]     addr_q;
  logic [data_width-1:0]     wdata_q, rdata_q, rdata_d;
  logic [data_width/8-1:0]   wmask_q;
  logic [cw-1:0]             cnt_q;
  logic                      bvalid_q, rvalid_q;
  logic [1:0]                bresp_q, rresp_q, resp_d;
  logic                      aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic                      wr_avail, rd_avail, grant_wr, issue, timeout, done;
  logic                      unused_prot;
  assign unused_prot = ^{s_axi_awprot_i, s_axi_arprot_i};
  // Handshakes, buffer next-state and arbitration decision; a handshake this cycle already counts as pending
  always_comb begin
    aw_hs     = s_axi_awvalid_i & aw_rdy_q;
    w_hs      = s_axi_wvalid_i & w_rdy_q;
    ar_hs     = s_axi_arvalid_i & ar_rdy_q;
    b_hs      = bvalid_q & s_axi_bready_i;
    r_hs      = rvalid_q & s_axi_rready_i;
    aw_full_d = b_hs ? 1'b0 : aw_full_q | aw_hs;
    w_full_d  = b_hs ? 1'b0 : w_full_q | w_hs;
    ar_full_d = r_hs ? 1'b0 : ar_full_q | ar_hs;
    aw_addr_d = aw_hs ? s_axi_awaddr_i : aw_addr_q;
    ar_addr_d = ar_hs ? s_axi_araddr_i : ar_addr_q;
    w_data_d  = w_hs ? s_axi_wdata_i : w_data_q;
    w_strb_d  = w_hs ? s_axi_wstrb_i : w_strb_q;
    wr_avail  = ~wr_iss_q & (aw_full_q | aw_hs) & (w_full_q | w_hs);
    rd_avail  = ~rd_iss_q & (ar_full_q | ar_hs);
    grant_wr  = wr_avail & (~rd_avail | ~last_wr_q);
    issue     = (state_q == IDLE) & (wr_avail | rd_avail);
    timeout   = (timeout_cycles != 0) && (cnt_q == cw'(timeout_cycles));
    done      = (state_q == ACCESS) & (reg_ack_i | timeout);
    resp_d    = (reg_ack_i & ~reg_err_i) ? 2'b00 : 2'b10;
    rdata_d   = reg_ack_i ? reg_rdata_i : '0;
    wr_iss_d  = b_hs ? 1'b0 : wr_iss_q | (issue & grant_wr);
    rd_iss_d  = r_hs ? 1'b0 : rd_iss_q | (issue & ~grant_wr);
  end
  // Channel buffers stay full, and their readys low, until the matching response handshake
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      ar_full_q <= 1'b0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      aw_rdy_q  <= 1'b0;
      w_rdy_q   <= 1'b0;
      ar_rdy_q  <= 1'b0;
      wr_iss_q  <= 1'b0;
      rd_iss_q  <= 1'b0;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      ar_full_q <= ar_full_d;
      aw_addr_q <= aw_addr_d;
      ar_addr_q <= ar_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      aw_rdy_q  <= ~aw_full_d;
      w_rdy_q   <= ~w_full_d;
      ar_rdy_q  <= ~ar_full_d;
      wr_iss_q  <= wr_iss_d;
      rd_iss_q  <= rd_iss_d;
    end
  end
  // Arbiter: issues one access at a time, holds it until ack or timeout, then posts the response
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      cnt_q     <= '0;
      last_wr_q <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      if (b_hs) bvalid_q <= 1'b0;
      if (r_hs) rvalid_q <= 1'b0;
      if (state_q == IDLE) begin
        if (issue) begin
          state_q   <= ACCESS;
          req_q     <= 1'b1;
          we_q      <= grant_wr;
          addr_q    <= (grant_wr ? aw_addr_d : ar_addr_d) & amask;
          wdata_q   <= grant_wr ? w_data_d : '0;
          wmask_q   <= grant_wr ? w_strb_d : '0;
          cnt_q     <= '0;
          last_wr_q <= grant_wr;
        end
      end else if (done) begin
        state_q <= IDLE;
        req_q   <= 1'b0;
        if (we_q) begin
          bvalid_q <= 1'b1;
          bresp_q  <= resp_d;
        end else begin
          rvalid_q <= 1'b1;
          rresp_q  <= resp_d;
          rdata_q  <= rdata_d;
        end
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
  assign reg_req_o       = req_q;
  assign reg_we_o        = we_q;
  assign reg_addr_o      = addr_q;
  assign reg_wdata_o     = wdata_q;
  assign reg_wmask_o     = wmask_q;
  assign s_axi_awready_o = aw_rdy_q;
  assign s_axi_wready_o  = w_rdy_q;
  assign s_axi_arready_o = ar_rdy_q;
  assign s_axi_bvalid_o  = bvalid_q;
  assign s_axi_bresp_o   = bresp_q;
  assign s_axi_rvalid_o  = rvalid_q;
  assign s_axi_rresp_o   = rresp_q;
  assign s_axi_rdata_o   = rdata_q;
endmodule

// File: tb/tb_axi4_lite_slave_arb.sv
// tb_axi4_lite_slave_arb: directed checks of capture, arbitration, timeout, backpressure and reset
module tb_axi4_lite_slave_arb;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        reg_req, reg_we, reg_ack, reg_err;
  logic [6:0]  reg_addr;
  logic [63:0] reg_wdata, reg_rdata;
  logic [7:0]  reg_wmask;
  logic [6:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = 3'd5, arprot = 3'd2;
  logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic        arvalid = 0, arready, rvalid, rready = 0;
  logic [63:0] wdata = '0, rdata;
  logic [7:0]  wstrb = '0;
  logic [1:0]  bresp, rresp;
  logic        ack_en = 0, err_en = 0;
  logic [63:0] rdata_val = '0;
  int          total = 0, passed = 0;
  int          req_total = 0, gn = 0;
  logic        glog [0:63];
  assign reg_ack   = ack_en & reg_req;
  assign reg_err   = err_en;
  assign reg_rdata = rdata_val;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (reg_req) req_total <= req_total + 1;
    if (reg_req && reg_ack) begin
      glog[gn[5:0]] <= reg_we;
      gn <= gn + 1;
    end
  end
  axi4_lite_slave_arb #(.addr_width(7), .data_width(64), .timeout_cycles(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .reg_req_o(reg_req), .reg_we_o(reg_we), .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata),
    .reg_wmask_o(reg_wmask), .reg_ack_i(reg_ack), .reg_err_i(reg_err), .reg_rdata_i(reg_rdata),
    .s_axi_awaddr_i(awaddr), .s_axi_awprot_i(awprot), .s_axi_awvalid_i(awvalid), .s_axi_awready_o(awready),
    .s_axi_wdata_i(wdata), .s_axi_wstrb_i(wstrb), .s_axi_wvalid_i(wvalid), .s_axi_wready_o(wready),
    .s_axi_bresp_o(bresp), .s_axi_bvalid_o(bvalid), .s_axi_bready_i(bready),
    .s_axi_araddr_i(araddr), .s_axi_arprot_i(arprot), .s_axi_arvalid_i(arvalid), .s_axi_arready_o(arready),
    .s_axi_rdata_o(rdata), .s_axi_rresp_o(rresp), .s_axi_rvalid_o(rvalid), .s_axi_rready_i(rready)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++; if (awready !== 1'b0) $display("FAIL rst_awready got %b exp 0", awready); else passed++;
    total++; if (wready !== 1'b0) $display("FAIL rst_wready got %b exp 0", wready); else passed++;
    total++; if (arready !== 1'b0) $display("FAIL rst_arready got %b exp 0", arready); else passed++;
    total++; if ({reg_req, bvalid, rvalid} !== 3'b000) $display("FAIL rst_valids got %b exp 000", {reg_req, bvalid, rvalid}); else passed++;
    rst_n = 1'b1;
    #1;
    total++; if (arready !== 1'b0) $display("FAIL rst_release_arready got %b exp 0", arready); else passed++;
    tick();
    total++; if ({awready, wready, arready} !== 3'b111) $display("FAIL rst_readys got %b exp 111", {awready, wready, arready}); else passed++;
  endtask
  task automatic test_read;
    ack_en = 1; rdata_val = 64'hDEADBEEF; araddr = 7'h10; arvalid = 1;
    tick();
    arvalid = 0;
    total++; if ({reg_req, reg_we} !== 2'b10) $display("FAIL rd_req got %b exp 10", {reg_req, reg_we}); else passed++;
    total++; if (reg_addr !== 7'h10) $display("FAIL rd_addr got %h exp 10", reg_addr); else passed++;
    total++; if (arready !== 1'b0) $display("FAIL rd_arready_busy got %b exp 0", arready); else passed++;
    tick();
    total++; if (rvalid !== 1'b1) $display("FAIL rd_rvalid got %b exp 1", rvalid); else passed++;
    total++; if (rdata !== 64'hDEADBEEF) $display("FAIL rd_rdata got %h exp deadbeef", rdata); else passed++;
    total++; if ({rresp, reg_req} !== 3'b000) $display("FAIL rd_rresp_req got %b exp 000", {rresp, reg_req}); else passed++;
    rready = 1;
    tick();
    rready = 0;
    total++; if ({rvalid, arready} !== 2'b01) $display("FAIL rd_after_hs got %b exp 01", {rvalid, arready}); else passed++;
  endtask
  task automatic test_write_w_first;
    int r0;
    r0 = req_total;
    wdata = 64'h12345678; wstrb = 8'h03; wvalid = 1;
    tick();
    wvalid = 0;
    total++; if ({wready, awready, reg_req} !== 3'b010) $display("FAIL wr_wonly got %b exp 010", {wready, awready, reg_req}); else passed++;
    tick();
    tick();
    awaddr = 7'h08; awvalid = 1;
    tick();
    awvalid = 0;
    total++; if ({reg_req, reg_we} !== 2'b11) $display("FAIL wr_req got %b exp 11", {reg_req, reg_we}); else passed++;
    total++; if (reg_wmask !== 8'h03) $display("FAIL wr_wmask got %h exp 03", reg_wmask); else passed++;
    total++; if (reg_wdata !== 64'h12345678) $display("FAIL wr_wdata got %h exp 12345678", reg_wdata); else passed++;
    total++; if (reg_addr !== 7'h08) $display("FAIL wr_addr got %h exp 08", reg_addr); else passed++;
    tick();
    total++; if ({bvalid, bresp} !== 3'b100) $display("FAIL wr_bresp got %b exp 100", {bvalid, bresp}); else passed++;
    total++; if (req_total - r0 !== 1) $display("FAIL wr_req_cycles got %0d exp 1", req_total - r0); else passed++;
    bready = 1;
    tick();
    total++; if ({bvalid, awready, wready} !== 3'b011) $display("FAIL wr_after_hs got %b exp 011", {bvalid, awready, wready}); else passed++;
  endtask
  task automatic test_round_robin;
    int g0;
    g0 = gn;
    rready = 1; bready = 1; rdata_val = 64'h0123456789ABCDEF;
    for (int k = 0; k < 2; k++) begin
      araddr = 7'h20; awaddr = 7'h28; wdata = 64'h55; wstrb = 8'hFF;
      arvalid = 1; awvalid = 1; wvalid = 1;
      tick();
      arvalid = 0; awvalid = 0; wvalid = 0;
      total++; if ({reg_req, reg_we} !== 2'b10) $display("FAIL rr%0d_first got %b exp 10", k, {reg_req, reg_we}); else passed++;
      tick();
      total++; if ({reg_req, rvalid} !== 2'b01) $display("FAIL rr%0d_gap got %b exp 01", k, {reg_req, rvalid}); else passed++;
      total++; if (rdata !== 64'h0123456789ABCDEF) $display("FAIL rr%0d_rdata got %h exp 0123456789abcdef", k, rdata); else passed++;
      tick();
      total++; if ({reg_req, reg_we} !== 2'b11) $display("FAIL rr%0d_second got %b exp 11", k, {reg_req, reg_we}); else passed++;
      repeat (3) tick();
    end
    total++; if (gn - g0 !== 4) $display("FAIL rr_count got %0d exp 4", gn - g0); else passed++;
    total++; if ({glog[g0], glog[g0+1], glog[g0+2], glog[g0+3]} !== 4'b0101) $display("FAIL rr_order got %b exp 0101", {glog[g0], glog[g0+1], glog[g0+2], glog[g0+3]}); else passed++;
    rready = 0; bready = 0;
  endtask
  task automatic test_timeout;
    int r0, k;
    ack_en = 0; rdata_val = 64'hCAFE; araddr = 7'h30; arvalid = 1;
    tick();
    arvalid = 0;
    r0 = req_total;
    k = 1;
    while (!rvalid && k < 20) begin
      tick();
      k++;
    end
    total++; if (k !== 6) $display("FAIL to_latency got %0d exp 6", k); else passed++;
    total++; if (rresp !== 2'b10) $display("FAIL to_rresp got %b exp 10", rresp); else passed++;
    total++; if (rdata !== 64'h0) $display("FAIL to_rdata got %h exp 0", rdata); else passed++;
    total++; if (req_total - r0 !== 5) $display("FAIL to_req_cycles got %0d exp 5", req_total - r0); else passed++;
    rready = 1;
    tick();
    rready = 0; ack_en = 1;
  endtask
  task automatic test_backpressure;
    logic bad, rv_seen;
    int g0;
    bad = 0; rv_seen = 0;
    bready = 0; rready = 1;
    awaddr = 7'h18; wdata = 64'hA5A5; wstrb = 8'h0F; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    tick();
    total++; if (bvalid !== 1'b1) $display("FAIL bp_bvalid got %b exp 1", bvalid); else passed++;
    g0 = gn;
    araddr = 7'h38; arvalid = 1;
    tick();
    arvalid = 0;
    for (int i = 0; i < 10; i++) begin
      if (awready || wready) bad = 1;
      if (rvalid) rv_seen = 1;
      tick();
    end
    total++; if (bad !== 1'b0) $display("FAIL bp_readys_low got %b exp 0", bad); else passed++;
    total++; if (rv_seen !== 1'b1) $display("FAIL bp_read_done got %b exp 1", rv_seen); else passed++;
    total++; if (gn - g0 !== 1 || glog[g0] !== 1'b0) $display("FAIL bp_grant got n=%0d we=%b exp n=1 we=0", gn - g0, glog[g0]); else passed++;
    total++; if ({bvalid, awready, wready} !== 3'b100) $display("FAIL bp_held got %b exp 100", {bvalid, awready, wready}); else passed++;
    bready = 1;
    tick();
    total++; if ({bvalid, awready, wready} !== 3'b011) $display("FAIL bp_release got %b exp 011", {bvalid, awready, wready}); else passed++;
    bready = 0; rready = 0;
  endtask
  task automatic test_err64;
    ack_en = 1; err_en = 1;
    awaddr = 7'h0C; wdata = 64'hFFFF_0000_1234_5678; wstrb = 8'hF0; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    total++; if (reg_addr !== 7'h08) $display("FAIL err_addr got %h exp 08", reg_addr); else passed++;
    total++; if (reg_wmask !== 8'hF0) $display("FAIL err_wmask got %h exp f0", reg_wmask); else passed++;
    tick();
    total++; if ({bvalid, bresp} !== 3'b110) $display("FAIL err_bresp got %b exp 110", {bvalid, bresp}); else passed++;
    bready = 1;
    tick();
    bready = 0; err_en = 0;
  endtask
  task automatic test_reset_mid;
    ack_en = 0; araddr = 7'h44; arvalid = 1;
    tick();
    arvalid = 0;
    total++; if (reg_req !== 1'b1) $display("FAIL rm_req_before got %b exp 1", reg_req); else passed++;
    #2 rst_n = 0;
    #1;
    total++; if ({reg_req, reg_we, awready, wready, arready, bvalid, rvalid} !== 7'b0) $display("FAIL rm_ctrl got %b exp 0000000", {reg_req, reg_we, awready, wready, arready, bvalid, rvalid}); else passed++;
    total++; if ({reg_addr, reg_wmask, bresp, rresp} !== 19'b0) $display("FAIL rm_data got %h exp 0", {reg_addr, reg_wmask, bresp, rresp}); else passed++;
    total++; if ({reg_wdata, rdata} !== 128'b0) $display("FAIL rm_wide got %h exp 0", {reg_wdata, rdata}); else passed++;
    rst_n = 1;
    tick();
    total++; if ({arready, reg_req} !== 2'b10) $display("FAIL rm_after got %b exp 10", {arready, reg_req}); else passed++;
  endtask
  initial begin
    test_reset();
    test_read();
    test_write_w_first();
    test_round_robin();
    test_timeout();
    test_backpressure();
    test_err64();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
endmodule
